seg7_scan_display: RTL and testbench

SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

---
 rtl/seg7_scan_display.sv | 163 ++++++++++++++++
 tb/tb_seg7_scan_display.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_display
// Description : Four-digit multiplexed seven-segment driver. A prescaler
//               divides gclk into digit slots, a 2-bit index scans DIG1..DIG4
//               and the last cycle of every slot is blanked (ghost guard).
//               New values are held pending and committed only at the frame
//               boundary so a frame never mixes two values.
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading zero
//               digits on DIG1..DIG3 (DIG4 always shows its glyph).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
  parameter int CLK_DIV = 50000  // gclk cycles per digit slot, 2..65535
) (
  input  logic        gclk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  output logic        DIG1,
  output logic        DIG2,
  output logic        DIG3,
  output logic        DIG4,
  output logic [6:0]  seg
);

  localparam logic [15:0] c_last    = 16'(CLK_DIV - 1);
  localparam logic [6:0]  c_seg_off = 7'b1111111;
  localparam logic [3:0]  c_dig_off = 4'b1111;

  logic [15:0] r_presc;
  logic [1:0]  r_index;
  logic [15:0] r_pending;
  logic [15:0] r_display;
  logic [3:0]  r_dig;      // {DIG1, DIG2, DIG3, DIG4}
  logic [6:0]  r_seg;

  logic        w_wrap;
  logic        w_frame_end;
  logic [3:0]  w_nibble;
  logic [6:0]  w_glyph;
  logic        w_blank;
  logic [3:0]  w_dig_next;
  logic [6:0]  w_seg_next;

  // The last prescaler count closes the slot; on index 3 it also closes the frame
  assign w_wrap      = (r_presc == c_last);
  assign w_frame_end = w_wrap && (r_index == 2'd3);

  // Prescaler and digit index: count within a slot, advance digit on wrap
  always_ff @(posedge gclk) begin
    if (rst) begin
      r_presc <= '0;
      r_index <= '0;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_index <= r_index + 2'd1;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  // Pending/display pair: display takes the pre-load pending value at the
  // frame boundary, so a coincident load lands one frame later
  always_ff @(posedge gclk) begin
    if (rst) begin
      r_pending <= '0;
      r_display <= '0;
    end else begin
      if (w_frame_end) begin
        r_display <= r_pending;
      end
      if (load) begin
        r_pending <= value;
      end
    end
  end

  // Select the nibble for the current digit; index 0 is the most significant
  always_comb begin
    w_nibble = r_display[15:12];
    case (r_index)
      2'd0:    w_nibble = r_display[15:12];
      2'd1:    w_nibble = r_display[11:8];
      2'd2:    w_nibble = r_display[7:4];
      default: w_nibble = r_display[3:0];
    endcase
  end

  // Hex to active-low abcdefg glyph
  always_comb begin
    w_glyph = c_seg_off;
    case (w_nibble)
      4'h0: w_glyph = 7'b0000001;
      4'h1: w_glyph = 7'b1001111;
      4'h2: w_glyph = 7'b0010010;
      4'h3: w_glyph = 7'b0000110;
      4'h4: w_glyph = 7'b1001100;
      4'h5: w_glyph = 7'b0100100;
      4'h6: w_glyph = 7'b0100000;
      4'h7: w_glyph = 7'b0001111;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0000100;
      4'hA: w_glyph = 7'b0001000;
      4'hB: w_glyph = 7'b1100000;
      4'hC: w_glyph = 7'b0110001;
      4'hD: w_glyph = 7'b1000010;
      4'hE: w_glyph = 7'b0110000;
      default: w_glyph = 7'b0111000;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank a digit when it and every more significant nibble are zero
  always_comb begin
    w_blank = 1'b0;
    case (r_index)
      2'd0:    w_blank = (r_display[15:12] == 4'h0);
      2'd1:    w_blank = (r_display[15:8]  == 8'h00);
      2'd2:    w_blank = (r_display[15:4]  == 12'h000);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  // Next digit enable and segment pattern; everything dark in the guard cycle
  always_comb begin
    w_dig_next = c_dig_off;
    w_seg_next = c_seg_off;
    if (!w_wrap) begin
      case (r_index)
        2'd0:    w_dig_next = 4'b0111;
        2'd1:    w_dig_next = 4'b1011;
        2'd2:    w_dig_next = 4'b1101;
        default: w_dig_next = 4'b1110;
      endcase
      if (!w_blank) begin
        w_seg_next = w_glyph;
      end
    end
  end

  // Registered outputs: one cycle behind the prescaler/index state
  always_ff @(posedge gclk) begin
    if (rst) begin
      r_dig <= c_dig_off;
      r_seg <= c_seg_off;
    end else begin
      r_dig <= w_dig_next;
      r_seg <= w_seg_next;
    end
  end

  assign DIG1 = r_dig[3];
  assign DIG2 = r_dig[2];
  assign DIG3 = r_dig[1];
  assign DIG4 = r_dig[0];
  assign seg  = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_display
// Description : Self-checking bench for seg7_scan_display with CLK_DIV=4.
//               Directed vector table, corner-case sequences and random
//               traffic, all checked against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_display;

  localparam int CLK_DIV = 4;
  localparam int FRAME   = 4 * CLK_DIV;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] c_z  = 7'b1111111;  // leading zero digit in a zero display
`else
  localparam logic [6:0] c_z  = 7'b0000001;
`endif
  localparam logic [6:0] c_off = 7'b1111111;

  logic        gclk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        DIG1, DIG2, DIG3, DIG4;
  logic [6:0]  seg;

  int errors;
  int checks;

  // reference model state: edges since reset, pending and displayed values
  int          m_n;
  logic [15:0] m_pend;
  logic [15:0] m_disp;

  typedef struct {
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dig;
    logic [6:0]  seg;
  } vec_t;

  vec_t vecs[$];

  seg7_scan_display #(.CLK_DIV(CLK_DIV)) dut (
    .gclk (gclk),
    .rst  (rst),
    .load (load),
    .value(value),
    .DIG1 (DIG1),
    .DIG2 (DIG2),
    .DIG3 (DIG3),
    .DIG4 (DIG4),
    .seg  (seg)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[h];
  endfunction

  task automatic check(input string name, input logic [3:0] ed, input logic [6:0] es);
    checks++;
    if ({DIG1, DIG2, DIG3, DIG4, seg} !== {ed, es}) begin
      errors++;
      $display("FAIL %s @%0t: got DIG=%b seg=%b, expected DIG=%b seg=%b",
               name, $time, {DIG1, DIG2, DIG3, DIG4}, seg, ed, es);
    end
  endtask

  // One clock: apply inputs, predict from the model, clock, compare
  task automatic step(input logic r, input logic l, input logic [15:0] v);
    logic [3:0] ed;
    logic [6:0] es;
    int p;
    int k;
    rst   = r;
    load  = l;
    value = v;
    ed = 4'b1111;
    es = c_off;
    p  = m_n % CLK_DIV;
    k  = (m_n / CLK_DIV) % 4;
    if (!r && p != CLK_DIV - 1) begin
      ed = ~(4'b1000 >> k);
      es = glyph(4'((m_disp >> (4 * (3 - k))) & 16'hF));
`ifdef LEADING_ZERO_BLANK_EN
      if (k < 3 && (m_disp >> (4 * (3 - k))) == 0) es = c_off;
`endif
    end
    if (r) begin
      m_n    = 0;
      m_pend = '0;
      m_disp = '0;
    end else begin
      if (p == CLK_DIV - 1 && k == 3) m_disp = m_pend;
      if (l) m_pend = v;
      m_n++;
    end
    @(posedge gclk);
    #1;
    check("model", ed, es);
  endtask

  // Idle until the model's position in the frame equals pos (bounded)
  task automatic run_until(input int pos);
    int guard;
    guard = 0;
    while ((m_n % FRAME) != pos && guard < 4 * FRAME) begin
      step(1'b0, 1'b0, 16'($urandom));
      guard++;
    end
    if ((m_n % FRAME) != pos) begin
      checks++;
      errors++;
      $display("FAIL run_until: position %0d not reached, at %0d", pos, m_n % FRAME);
    end
  endtask

  task automatic push(input logic r, input logic l, input logic [15:0] v,
                      input logic [3:0] d, input logic [6:0] s);
    vec_t e;
    e.rst = r; e.load = l; e.value = v; e.dig = d; e.seg = s;
    vecs.push_back(e);
  endtask

  // Three active cycles then the guard cycle
  task automatic push_slot(input logic [3:0] d, input logic [6:0] s);
    for (int i = 0; i < CLK_DIV - 1; i++) push(1'b0, 1'b0, 16'h0, d, s);
    push(1'b0, 1'b0, 16'h0, 4'b1111, c_off);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_n    = 0;
    m_pend = '0;
    m_disp = '0;
    rst    = 1'b1;
    load   = 1'b0;
    value  = '0;

    // reset, release with a load of A5C0, zero frame, then the A5C0 frame
    push(1'b1, 1'b0, 16'h0, 4'b1111, c_off);
    push(1'b1, 1'b0, 16'h0, 4'b1111, c_off);
    push(1'b0, 1'b1, 16'hA5C0, 4'b0111, c_z);
    push(1'b0, 1'b0, 16'h0, 4'b0111, c_z);
    push(1'b0, 1'b0, 16'h0, 4'b0111, c_z);
    push(1'b0, 1'b0, 16'h0, 4'b1111, c_off);
    push_slot(4'b1011, c_z);
    push_slot(4'b1101, c_z);
    push_slot(4'b1110, 7'b0000001);
    push_slot(4'b0111, 7'b0001000);
    push_slot(4'b1011, 7'b0100100);
    push_slot(4'b1101, 7'b0110001);
    push_slot(4'b1110, 7'b0000001);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].load, vecs[i].value);
      check($sformatf("vec[%0d]", i), vecs[i].dig, vecs[i].seg);
    end

    // tear-free update: two loads mid-frame, only the last shows next frame
    run_until(5);
    step(1'b0, 1'b1, 16'h1111);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h2222);
    run_until(13);
    step(1'b0, 1'b0, 16'h0);
    check("tear_old", 4'b1110, 7'b0000001);
    run_until(0);
    step(1'b0, 1'b0, 16'h0);
    check("tear_new", 4'b0111, 7'b0010010);

    // load exactly on the frame boundary with 8888 already pending
    run_until(8);
    step(1'b0, 1'b1, 16'h8888);
    run_until(15);
    step(1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 16'h0);
    check("collide_first", 4'b0111, 7'b0000000);
    run_until(0);
    step(1'b0, 1'b0, 16'h0);
    check("collide_next", 4'b0111, 7'b0111000);

    // leading-zero values
    run_until(4);
    step(1'b0, 1'b1, 16'h000F);
    run_until(0);
    step(1'b0, 1'b0, 16'h0);
    check("lz_000F_dig1", 4'b0111, c_z);
    run_until(12);
    step(1'b0, 1'b1, 16'h0000);
    check("lz_000F_dig4", 4'b1110, 7'b0111000);
    run_until(12);
    run_until(0);
    run_until(12);
    step(1'b0, 1'b0, 16'h0);
    check("lz_0000_dig4", 4'b1110, 7'b0000001);

    // reset during index 2 with a pending load
    run_until(0);
    step(1'b0, 1'b1, 16'h4321);
    run_until(0);
    run_until(8);
    step(1'b0, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 16'h5678);
    check("rst_mid", 4'b1111, c_off);
    step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    check("rst_release", 4'b0111, c_z);
    run_until(0);
    step(1'b0, 1'b0, 16'h0);
    check("rst_discard", 4'b0111, c_z);
    run_until(12);
    step(1'b0, 1'b0, 16'h0);
    check("rst_discard_dig4", 4'b1110, 7'b0000001);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(0, 2) == 0) v = v >> (4 * $urandom_range(1, 4));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
